cfg_ls_stream_sel_loader: RTL
=============================

// Module: cfg_ls_stream_sel_loader
// PURPOSE
//  Writer side of the load/store stream-select configuration store.
//  - Accepts a burst of 32-bit config words over a valid/ready stream.
//  - Writes them into the per-group / per-bank / per-kernel-slot L and S stream-select
//    register arrays. These arrays are the storage that the per-cycle selection logic
//    later indexes with the reconfiguration control address.
//  - Sits between the host config bus front-end and the crossbar select-decode logic.
// PARAMETERS
//  WORD_W       32  stream word width; fixed, must be >= 16
//  (N_BANKS_GROUP, N_BANKS_PER_STREAM, KMEM_SIZE, LOG_N_AGE_PER_STREAM,
//   LOG_N_PE_PER_GROUP, N_CFG_ADDR_BITS come from the mage/xbar/pea packages)
// PORTS
//  clk_i            in   1                                     clock
//  rst_i            in   1                                     sync reset, active-high
//  start_i          in   1                                     begin burst; sampled in IDLE only
//  kmem_base_i      in   N_CFG_ADDR_BITS                       first kernel slot to write
//  n_entries_i      in   N_CFG_ADDR_BITS+1                     number of kernel slots to write
//  word_valid_i     in   1                                     stream word valid
//  word_data_i      in   WORD_W                                [7:0]=l_sel (zero-ext), [15:8]=s_sel, rest ignored
//  word_ready_o     out  1                                     loader accepts word
//  busy_o           out  1                                     FSM not IDLE
//  done_o           out  1                                     1-cycle pulse, burst finished
//  err_o            out  1                                     1-cycle pulse with done_o, range rejected
//  reg_cfg_l_stream_sel_o  out  [N_BANKS_GROUP][N_BANKS_PER_STREAM][KMEM_SIZE][LOG_N_AGE_PER_STREAM]
//  reg_cfg_s_stream_sel_o  out  [N_BANKS_GROUP][N_BANKS_PER_STREAM][KMEM_SIZE][LOG_N_PE_PER_GROUP]
// BEHAVIOUR
//  - Reset: all array entries 0, FSM IDLE. word_ready_o, busy_o, done_o, err_o all 0.
//  - States and transitions:
//    - IDLE --start_i--> CHECK (latch base, count).
//    - CHECK: if base+count > KMEM_SIZE -> DONE with err. If count==0 -> DONE, no err.
//      Otherwise -> LOAD.
//    - LOAD: word_ready_o=1. On each valid&&ready, write slot
//      [grp][bank][kmem_ptr] l/s fields (truncated to field widths).
//      - Slot order: bank fastest, then group, then kmem_ptr (base upward).
//      - Last word of last entry -> DONE.
//    - DONE: done_o=1 (and err_o if rejected) for exactly one cycle -> IDLE.
//  - Counters:
//    - bank_cnt wraps at N_BANKS_PER_STREAM and increments grp_cnt.
//    - grp_cnt wraps at N_BANKS_GROUP and increments kmem_ptr and entry_cnt.
//    - Words per burst = count*N_BANKS_GROUP*N_BANKS_PER_STREAM.
//  - Latency: a written value is visible on the outputs the cycle after its handshake.
//    done_o is asserted the cycle after the last handshake.
//  - start_i while busy_o: ignored. word_valid_i outside LOAD: not accepted (ready=0).
//  - word_valid_i low in LOAD: stall, counters hold, no timeout.
//  - Rejected burst: no array writes, no words consumed.
//  - Slots not addressed by a burst keep their previous values.
//  - rst_i mid-burst: arrays cleared, FSM IDLE, partial burst discarded.
//  - Width arithmetic: base+count is computed in N_CFG_ADDR_BITS+2 bits, so it does not overflow.
// CONFIGURATION
//  CFG_LS_SEL_READBACK_EN defined:
//    - Adds rb_kmem_i / rb_grp_i / rb_bank_i inputs and rb_data_o (WORD_W).
//    - rb_data_o is registered (1-cycle latency) and packed the same way as word_data_i;
//      unused bits are 0.
//    - Reads the stored value even during LOAD; a same-cycle write returns the old value.
//  Undefined: readback ports are absent, no extra logic.
// STRUCTURE
//  - Package mage_pkg:
//    - typedef ld_state_e {IDLE,CHECK,LOAD,DONE}.
//    - CFG_LS_SEL_L_LSB=0, CFG_LS_SEL_S_LSB=8.
//    - N_LS_SEL_SLOTS = N_BANKS_GROUP*N_BANKS_PER_STREAM.
//  - One sub-module, cfg_ls_sel_slot_cnt: the nested bank/grp/kmem counter with a
//    last-slot flag. FSM and storage stay in the top.
// TESTING
//  1. Reset, then read all arrays -> all 0. busy_o=0, word_ready_o=0.
//  2. base=0, count=1, feed N_LS_SEL_SLOTS words with l=k, s=k+1 (mod field width)
//     -> slot k holds the values. done_o pulses once, err_o=0.
//  3. base=KMEM_SIZE-1, count=2 -> err_o=done_o=1 two cycles after start.
//     Arrays unchanged, no word accepted.
//  4. count=0 -> done_o pulses two cycles after start, err_o=0, arrays unchanged.
//  5. Burst with random valid gaps, plus start_i pulsed mid-burst -> identical array
//     contents to a gapless burst; start ignored.
//  6. rst_i asserted after half of a 2-entry burst -> arrays all 0, IDLE.
//     A new burst then completes normally.
//  7. (CFG_LS_SEL_READBACK_EN) write kmem 3 grp 1 bank 0 = l:2 s:1
//     -> rb_data_o = 0x0102 one cycle after addressing it.

Source files
------------

// File: rtl/cfg_ls_stream_sel_loader_pkg.sv
// Shared types and sizing for the load/store stream-select configuration loader.
// Optional readback is controlled by CFG_LS_SEL_READBACK_EN (see top module).
package mage_pkg;

    localparam int unsigned WORD_W               = 32;
    localparam int unsigned N_BANKS_GROUP        = 2;
    localparam int unsigned N_BANKS_PER_STREAM   = 4;
    localparam int unsigned KMEM_SIZE            = 8;
    localparam int unsigned LOG_N_AGE_PER_STREAM = 3;
    localparam int unsigned LOG_N_PE_PER_GROUP   = 2;
    localparam int unsigned N_CFG_ADDR_BITS      = 3;

    localparam int unsigned CFG_LS_SEL_L_LSB = 0;
    localparam int unsigned CFG_LS_SEL_S_LSB = 8;
    localparam int unsigned N_LS_SEL_SLOTS   = N_BANKS_GROUP * N_BANKS_PER_STREAM;

    localparam int unsigned BANK_W = (N_BANKS_PER_STREAM > 1) ? $clog2(N_BANKS_PER_STREAM) : 1;
    localparam int unsigned GRP_W  = (N_BANKS_GROUP > 1) ? $clog2(N_BANKS_GROUP) : 1;

    localparam logic [BANK_W-1:0] BANK_MAX = BANK_W'(N_BANKS_PER_STREAM - 1);
    localparam logic [GRP_W-1:0]  GRP_MAX  = GRP_W'(N_BANKS_GROUP - 1);

    typedef enum logic [1:0] {IDLE, CHECK, LOAD, DONE} ld_state_e;

endpackage

// File: rtl/cfg_ls_stream_sel_loader_if.sv
// Burst control and config-word stream between the host front-end (master) and the loader (slave).
interface cfg_ls_stream_sel_loader_if import mage_pkg::*; ();

    logic                       start_i;
    logic [N_CFG_ADDR_BITS-1:0] kmem_base_i;
    logic [N_CFG_ADDR_BITS:0]   n_entries_i;
    logic                       word_valid_i;
    logic [WORD_W-1:0]          word_data_i;
    logic                       word_ready_o;
    logic                       busy_o;
    logic                       done_o;
    logic                       err_o;

    modport master (
        output start_i, kmem_base_i, n_entries_i, word_valid_i, word_data_i,
        input  word_ready_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, kmem_base_i, n_entries_i, word_valid_i, word_data_i,
        output word_ready_o, busy_o, done_o, err_o
    );

endinterface

// File: rtl/cfg_ls_sel_slot_cnt.sv
// Nested slot counter: bank fastest, then group, then kernel slot; flags the final slot of a burst.
module cfg_ls_sel_slot_cnt
    import mage_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       init_i,
    input  logic                       adv_i,
    input  logic [N_CFG_ADDR_BITS-1:0] base_i,
    input  logic [N_CFG_ADDR_BITS:0]   count_i,
    output logic [BANK_W-1:0]          bank_o,
    output logic [GRP_W-1:0]           grp_o,
    output logic [N_CFG_ADDR_BITS-1:0] kmem_o,
    output logic                       last_o
);

    logic [BANK_W-1:0]          bank_q;
    logic [GRP_W-1:0]           grp_q;
    logic [N_CFG_ADDR_BITS-1:0] kmem_q;
    logic [N_CFG_ADDR_BITS:0]   entry_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bank_q  <= '0;
            grp_q   <= '0;
            kmem_q  <= '0;
            entry_q <= '0;
        end else if (init_i) begin
            bank_q  <= '0;
            grp_q   <= '0;
            kmem_q  <= base_i;
            entry_q <= '0;
        end else if (adv_i) begin
            if (bank_q == BANK_MAX) begin
                bank_q <= '0;
                if (grp_q == GRP_MAX) begin
                    grp_q   <= '0;
                    kmem_q  <= kmem_q + 1'b1;
                    entry_q <= entry_q + 1'b1;
                end else begin
                    grp_q <= grp_q + 1'b1;
                end
            end else begin
                bank_q <= bank_q + 1'b1;
            end
        end
    end

    assign bank_o = bank_q;
    assign grp_o  = grp_q;
    assign kmem_o = kmem_q;
    // Only meaningful while loading, where count_i is known to be non-zero.
    assign last_o = (bank_q == BANK_MAX) && (grp_q == GRP_MAX) && (entry_q == count_i - 1'b1);

endmodule

// File: rtl/cfg_ls_stream_sel_loader.sv
// Writer side of the L/S stream-select configuration store: burst-loads per-slot select fields.
// Define CFG_LS_SEL_READBACK_EN to add a registered readback port.
module cfg_ls_stream_sel_loader
    import mage_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    cfg_ls_stream_sel_loader_if.slave bus,
    output logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][KMEM_SIZE-1:0][LOG_N_AGE_PER_STREAM-1:0] reg_cfg_l_stream_sel_o,
    output logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][KMEM_SIZE-1:0][LOG_N_PE_PER_GROUP-1:0]   reg_cfg_s_stream_sel_o
`ifdef CFG_LS_SEL_READBACK_EN
    ,
    input  logic [N_CFG_ADDR_BITS-1:0] rb_kmem_i,
    input  logic [GRP_W-1:0]           rb_grp_i,
    input  logic [BANK_W-1:0]          rb_bank_i,
    output logic [WORD_W-1:0]          rb_data_o
`endif
);

    localparam logic [N_CFG_ADDR_BITS+1:0] KMEM_LIMIT = (N_CFG_ADDR_BITS + 2)'(KMEM_SIZE);

    ld_state_e                  state_q;
    logic [N_CFG_ADDR_BITS-1:0] base_q;
    logic [N_CFG_ADDR_BITS:0]   count_q;
    logic                       ready_q, busy_q, done_q, err_q;
    logic [N_CFG_ADDR_BITS+1:0] end_sum;
    logic                       fire, last_slot;
    logic [BANK_W-1:0]          bank;
    logic [GRP_W-1:0]           grp;
    logic [N_CFG_ADDR_BITS-1:0] kmem;
    logic                       unused_data;

    logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][KMEM_SIZE-1:0][LOG_N_AGE_PER_STREAM-1:0] l_sel_q;
    logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][KMEM_SIZE-1:0][LOG_N_PE_PER_GROUP-1:0]   s_sel_q;

    assign end_sum = {2'b00, base_q} + {1'b0, count_q};
    assign fire    = bus.word_valid_i && ready_q;
    // Word bits above the two fields are ignored by design.
    assign unused_data = ^bus.word_data_i;

    cfg_ls_sel_slot_cnt u_slot_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .init_i  (state_q == CHECK),
        .adv_i   (fire),
        .base_i  (base_q),
        .count_i (count_q),
        .bank_o  (bank),
        .grp_o   (grp),
        .kmem_o  (kmem),
        .last_o  (last_slot)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            l_sel_q <= '0;
            s_sel_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        base_q  <= bus.kmem_base_i;
                        count_q <= bus.n_entries_i;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (end_sum > KMEM_LIMIT) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (count_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (fire) begin
                        l_sel_q[grp][bank][kmem] <= bus.word_data_i[CFG_LS_SEL_L_LSB +: LOG_N_AGE_PER_STREAM];
                        s_sel_q[grp][bank][kmem] <= bus.word_data_i[CFG_LS_SEL_S_LSB +: LOG_N_PE_PER_GROUP];
                        if (last_slot) begin
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.word_ready_o = ready_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;

    assign reg_cfg_l_stream_sel_o = l_sel_q;
    assign reg_cfg_s_stream_sel_o = s_sel_q;

`ifdef CFG_LS_SEL_READBACK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rb_data_o <= '0;
        end else begin
            rb_data_o <= '0;
            rb_data_o[CFG_LS_SEL_L_LSB +: LOG_N_AGE_PER_STREAM] <= l_sel_q[rb_grp_i][rb_bank_i][rb_kmem_i];
            rb_data_o[CFG_LS_SEL_S_LSB +: LOG_N_PE_PER_GROUP]   <= s_sel_q[rb_grp_i][rb_bank_i][rb_kmem_i];
        end
    end
`endif

endmodule
